// File: rtl/uart_pkg.sv
// Shared UART clocking constants and the fixed-point baud divisor helper.
package uart_pkg;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned DEFAULT_BAUD = 115_200;
  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned DIV_INT_W    = 16;
  localparam int unsigned DIV_FRAC_W   = 4;
  localparam int unsigned DIV_W        = DIV_INT_W + DIV_FRAC_W;

  typedef logic [DIV_W-1:0] div_t;

  // Rounded CLK_HZ * 2^DIV_FRAC_W / (baud * os), as {int, frac}.
  function automatic div_t calc_div(input longint unsigned clk_hz,
                                    input longint unsigned baud,
                                    input longint unsigned os);
    longint unsigned den;
    den = baud * os;
    return div_t'(((clk_hz << DIV_FRAC_W) + den / 2) / den);
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional interval divider: cycle counter plus dithering accumulator,
// producing the raw oversample tick on the last cycle of each interval.
module baud_frac_div
  import uart_pkg::*;
#(
  parameter int unsigned DIV_INT_W  = uart_pkg::DIV_INT_W,
  parameter int unsigned DIV_FRAC_W = uart_pkg::DIV_FRAC_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  restart,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  output logic                  tick
);

  logic [DIV_INT_W-1:0]  cnt;
  logic [DIV_INT_W-1:0]  lim;
  logic [DIV_FRAC_W-1:0] frac_acc;
  logic                  ext;
  logic [DIV_FRAC_W:0]   sum;

  assign lim  = div_int - DIV_INT_W'(1) + DIV_INT_W'(ext);
  assign tick = en && (cnt == lim);
  // Extra MSB keeps the carry that stretches the next interval by one cycle.
  assign sum  = {1'b0, frac_acc} + {1'b0, div_frac};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      frac_acc <= '0;
      ext      <= 1'b0;
    end else if (!en) begin
      cnt      <= '0;
      frac_acc <= '0;
      ext      <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      if (restart) begin
        frac_acc <= '0;
        ext      <= 1'b0;
      end else begin
        frac_acc <= sum[DIV_FRAC_W-1:0];
        ext      <= sum[DIV_FRAC_W];
      end
    end else begin
      cnt <= cnt + DIV_INT_W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// Programmable fractional baud generator: oversample and bit strobes with
// a double-buffered divisor that only changes on bit boundaries.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ       = uart_pkg::CLK_HZ,
  parameter int unsigned DEFAULT_BAUD = uart_pkg::DEFAULT_BAUD,
  parameter int unsigned OVERSAMPLE   = uart_pkg::OVERSAMPLE,
  parameter int unsigned DIV_INT_W    = uart_pkg::DIV_INT_W,
  parameter int unsigned DIV_FRAC_W   = uart_pkg::DIV_FRAC_W
) (
  input  logic                              clk_50mhz,
  input  logic                              rst,
  input  logic                              en,
  input  logic [DIV_INT_W+DIV_FRAC_W-1:0]   div_in,
  input  logic                              div_load,
  output logic                              rxclk_en,
  output logic                              txclk_en,
  output logic [$clog2(OVERSAMPLE)-1:0]     os_phase,
  output logic [DIV_INT_W+DIV_FRAC_W-1:0]   div_active,
  output logic                              cfg_err
);

  localparam int unsigned DW   = DIV_INT_W + DIV_FRAC_W;
  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam logic [DW-1:0]   DEFAULT_DIV =
    DW'(calc_div(CLK_HZ, DEFAULT_BAUD, OVERSAMPLE));
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [DW-1:0] pending;
  logic          pend;
  logic          tick;
  logic          last;
  logic          load_ok;
  logic          apply;

  assign last    = (os_phase == OS_LAST);
  assign load_ok = div_load && (div_in[DW-1:DIV_FRAC_W] >= DIV_INT_W'(2));
  // Swap only at a bit boundary so a bit is never timed with two divisors.
  assign apply   = pend && (!en || (tick && last));

  baud_frac_div #(
    .DIV_INT_W (DIV_INT_W),
    .DIV_FRAC_W(DIV_FRAC_W)
  ) u_frac_div (
    .clk     (clk_50mhz),
    .rst     (rst),
    .en      (en),
    .restart (pend && last),
    .div_int (div_active[DW-1:DIV_FRAC_W]),
    .div_frac(div_active[DIV_FRAC_W-1:0]),
    .tick    (tick)
  );

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      div_active <= DEFAULT_DIV;
      pending    <= DEFAULT_DIV;
      pend       <= 1'b0;
      cfg_err    <= 1'b0;
      os_phase   <= '0;
      rxclk_en   <= 1'b0;
      txclk_en   <= 1'b0;
    end else begin
      cfg_err <= div_load && !load_ok;
      if (apply) begin
        div_active <= pending;
        pend       <= 1'b0;
      end
      // A load on the apply edge wins over the pend clear above.
      if (load_ok) begin
        pending <= div_in;
        pend    <= 1'b1;
      end
      if (!en) begin
        os_phase <= '0;
        rxclk_en <= 1'b0;
        txclk_en <= 1'b0;
      end else begin
        rxclk_en <= tick;
        txclk_en <= tick && last;
        if (tick) os_phase <= last ? '0 : os_phase + OS_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac against a closed-form timing model.
module tb_baud_gen_frac;

  localparam int DW     = 20;
  localparam int FSCALE = 16;
  localparam int OS     = 16;
  localparam logic [DW-1:0] DEF_DIV = 20'd434;

  logic          clk_50mhz = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] div_in;
  logic          div_load;
  logic          rxclk_en;
  logic          txclk_en;
  logic [3:0]    os_phase;
  logic [DW-1:0] div_active;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  always #10 clk_50mhz = ~clk_50mhz;

  baud_gen_frac #(
    .CLK_HZ      (50_000_000),
    .DEFAULT_BAUD(115_200),
    .OVERSAMPLE  (16),
    .DIV_INT_W   (16),
    .DIV_FRAC_W  (4)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_load  (div_load),
    .rxclk_en  (rxclk_en),
    .txclk_en  (txclk_en),
    .os_phase  (os_phase),
    .div_active(div_active),
    .cfg_err   (cfg_err)
  );

  // Reference: the k-th strobe after a restart lands n = k*I + floor((k-1)*F/2^4)
  // edges after it; a restart is an enable restart or a divisor swap.
  logic [DW-1:0] m_div = DEF_DIV;
  logic [DW-1:0] m_pending = '0;
  logic          m_pend = 1'b0;
  int            n = 0, k = 1, mos = 0, mi, mf;
  logic          e_rx = 0, e_tx = 0, e_err = 0;
  logic [3:0]    e_os = '0;

  initial forever begin
    @(posedge clk_50mhz or posedge rst);
    if (rst) begin
      m_div = DEF_DIV; m_pend = 0; m_pending = '0; n = 0; k = 1; mos = 0;
      e_rx = 0; e_tx = 0; e_err = 0; e_os = '0;
    end else begin
      mi = int'(m_div) / FSCALE;
      mf = int'(m_div) % FSCALE;
      e_err = div_load && (int'(div_in) / FSCALE < 2);
      e_rx = 0; e_tx = 0;
      if (!en) begin
        n = 0; k = 1; mos = 0;
        if (m_pend) begin m_div = m_pending; m_pend = 0; end
      end else begin
        n++;
        if (n == k * mi + ((k - 1) * mf) / FSCALE) begin
          e_rx = 1; k++;
          mos = (mos + 1) % OS;
          e_tx = (mos == 0);
          if (e_tx && m_pend) begin m_div = m_pending; m_pend = 0; n = 0; k = 1; end
        end
      end
      e_os = 4'(mos);
      if (div_load && !e_err) begin m_pending = div_in; m_pend = 1; end
    end
  end

  task automatic test_reset();
    rst = 1; en = 0; div_load = 0; div_in = '0;
    #15;
    checks++;
    if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {1'b0, 1'b0, 4'd0, 1'b0, DEF_DIV}) begin
      errors++; $display("FAIL reset_state got %h want %h", {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {1'b0, 1'b0, 4'd0, 1'b0, DEF_DIV});
    end
    @(negedge clk_50mhz); rst = 0;
    repeat (4) begin
      @(negedge clk_50mhz);
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL reset_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
    end
  endtask

  task automatic test_default_rate();
    int e, nrx, ntx, last_tx;
    int rx_exp[9];
    rx_exp = '{27, 54, 81, 108, 135, 162, 189, 216, 244};
    en = 1; e = 0; nrx = 0; ntx = 0; last_tx = 0;
    repeat (1310) begin
      @(negedge clk_50mhz); e++;
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL default_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
      if (rxclk_en && nrx < 9) begin
        checks++;
        if (e !== rx_exp[nrx]) begin errors++; $display("FAIL default_rx%0d edge %0d want %0d", nrx, e, rx_exp[nrx]); end
        nrx++;
      end
      if (txclk_en) begin
        checks++;
        if (e - last_tx !== (ntx == 0 ? 433 : 434)) begin
          errors++; $display("FAIL default_tx%0d spacing %0d want %0d", ntx, e - last_tx, ntx == 0 ? 433 : 434);
        end
        last_tx = e; ntx++;
      end
    end
    checks++;
    if (ntx !== 3) begin errors++; $display("FAIL default_tx_count got %0d want 3", ntx); end
  endtask

  task automatic test_integer();
    int e, last_rx, last_tx, ntx;
    en = 0; div_in = 20'd432; div_load = 1;
    repeat (3) begin
      @(negedge clk_50mhz);
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL integer_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
      div_load = 0;
    end
    checks++;
    if (div_active !== 20'd432) begin errors++; $display("FAIL integer_load got %0d want 432", div_active); end
    en = 1; e = 0; last_rx = 0; last_tx = 0; ntx = 0;
    repeat (432 * 2 + 5) begin
      @(negedge clk_50mhz); e++;
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL integer_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
      if (rxclk_en) begin
        checks++;
        if (e - last_rx !== 27) begin errors++; $display("FAIL integer_rx spacing %0d want 27", e - last_rx); end
        last_rx = e;
      end
      if (txclk_en) begin
        checks++;
        if (e - last_tx !== 432) begin errors++; $display("FAIL integer_tx spacing %0d want 432", e - last_tx); end
        last_tx = e; ntx++;
      end
    end
    checks++;
    if (ntx !== 2) begin errors++; $display("FAIL integer_tx_count got %0d want 2", ntx); end
  endtask

  task automatic test_deferred();
    int e;
    int txq[$];
    div_in = 20'd160; div_load = 1; e = 0;
    repeat (760) begin
      @(negedge clk_50mhz); e++;
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL deferred_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
      div_load = 0;
      if (txclk_en) txq.push_back(e);
    end
    checks++;
    if (txq.size() < 3 || txq[1] - txq[0] !== 160 || txq[2] - txq[1] !== 160 || div_active !== 20'd160) begin
      errors++; $display("FAIL deferred_single ntx=%0d div=%0d want 3+ bits of 160", txq.size(), div_active);
    end
    txq.delete();
    div_in = 20'h000C8; div_load = 1; e = 0;
    repeat (540) begin
      @(negedge clk_50mhz); e++;
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL deferred2_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
      div_load = 0;
      if (e == 20) begin div_in = 20'h000C0; div_load = 1; end
      if (txclk_en) txq.push_back(e);
    end
    checks++;
    if (txq.size() < 3 || txq[1] - txq[0] !== 192 || txq[2] - txq[1] !== 192 || div_active !== 20'h000C0) begin
      errors++; $display("FAIL deferred_last_wins ntx=%0d div=%h want 3+ bits of 192", txq.size(), div_active);
    end
  endtask

  task automatic test_invalid();
    div_in = 20'h00018; div_load = 1;
    @(negedge clk_50mhz); div_load = 0;
    checks++;
    if (cfg_err !== 1'b1 || div_active !== 20'h000C0) begin
      errors++; $display("FAIL invalid_pulse err=%b div=%h want err=1 div=0c0", cfg_err, div_active);
    end
    repeat (400) begin
      @(negedge clk_50mhz);
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL invalid_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
    end
    checks++;
    if (div_active !== 20'h000C0) begin errors++; $display("FAIL invalid_keep div=%h want 0c0", div_active); end
  endtask

  task automatic test_enable_reset();
    int e;
    logic found;
    en = 0; div_in = 20'h000A5; div_load = 1;
    @(negedge clk_50mhz);
    checks++;
    if (os_phase !== 4'd0 || rxclk_en !== 1'b0) begin
      errors++; $display("FAIL hold_idle os=%0d rx=%b want 0 0", os_phase, rxclk_en);
    end
    div_in = 20'h000C0;
    @(negedge clk_50mhz); div_load = 0;
    checks++;
    if (div_active !== 20'h000A5) begin errors++; $display("FAIL hold_apply_first div=%h want 0a5", div_active); end
    @(negedge clk_50mhz);
    checks++;
    if (div_active !== 20'h000C0) begin errors++; $display("FAIL hold_apply_second div=%h want 0c0", div_active); end
    en = 1; e = 0; found = 0;
    while (!found && e < 50) begin
      @(negedge clk_50mhz); e++; found = rxclk_en;
    end
    checks++;
    if (e !== 12 || os_phase !== 4'd1) begin
      errors++; $display("FAIL restart_first_rx edge=%0d os=%0d want 12 1", e, os_phase);
    end
    div_in = 20'h00140; div_load = 1;
    @(negedge clk_50mhz); div_load = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk_50mhz); #1 found = rxclk_en;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wait_rx timed out got 0 want 1"); end
    #3 rst = 1;
    #1;
    checks++;
    if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {1'b0, 1'b0, 4'd0, 1'b0, DEF_DIV}) begin
      errors++; $display("FAIL async_reset got %h want %h", {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {1'b0, 1'b0, 4'd0, 1'b0, DEF_DIV});
    end
    @(negedge clk_50mhz); rst = 0;
    repeat (500) begin
      @(negedge clk_50mhz);
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL post_reset_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
    end
    checks++;
    if (div_active !== DEF_DIV) begin errors++; $display("FAIL pending_dropped div=%h want %h", div_active, DEF_DIV); end
  endtask

  task automatic test_random();
    int action, cycles;
    repeat (40) begin
      action = $urandom_range(0, 3);
      if (action == 0) en = ~en;
      else if (action != 3) begin
        div_in = {16'($urandom_range(0, 12)), 4'($urandom)};
        div_load = 1;
      end
      cycles = $urandom_range(1, 150);
      repeat (cycles) begin
        @(negedge clk_50mhz);
        checks++;
        if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
          errors++; $display("FAIL random_model @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
        end
        div_load = 0;
      end
    end
    en = 1;
    repeat (300) begin
      @(negedge clk_50mhz);
      checks++;
      if ({rxclk_en, txclk_en, os_phase, cfg_err, div_active} !== {e_rx, e_tx, e_os, e_err, m_div}) begin
        errors++; $display("FAIL random_tail @%0t got %h want %h", $time, {rxclk_en, txclk_en, os_phase, cfg_err, div_active}, {e_rx, e_tx, e_os, e_err, m_div});
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_rate();
    test_integer();
    test_deferred();
    test_invalid();
    test_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
